// File: rtl/wrapped_core_gate.sv
// ---------------------------------------------------------------------------
// wrapped_core_gate
//   Power-sequencing gate between the harness and a wrapped user core. The
//   core is held in reset and its outputs are isolated until the project has
//   been selected and a settle interval has elapsed. On deselection it is held
//   in reset for a drain interval before returning to idle. A CPU-driven soft
//   reset (LA bit 0) re-runs the settle interval without leaving selection.
//
// Ports
//   wb_clk_i      in   1        sole clock, rising edge
//   wb_rst_i      in   1        asynchronous active-high reset
//   active        in   1        project select, asynchronous to wb_clk_i
//   la1_data_in   in   LA_W     CPU -> LA data, bit 0 = soft-reset request
//   la1_oenb      in   LA_W     LA output enable bar, bit 0 qualifies request
//   core_la_out   in   LA_W     LA data from the core
//   core_io_out   in   IO_PADS  pad data from the core
//   la1_data_out  out  LA_W     gated core_la_out
//   io_out        out  IO_PADS  gated core_io_out
//   io_oeb        out  IO_PADS  gated OEB_DEFAULT
//   core_rst_o    out  1        registered reset to the core, active-high
//   status_o      out  18       {state[1:0], run_count[15:0]}, never gated
//
// States
//   state  | meaning
//   OFF    | idle, core in reset, outputs isolated
//   SETTLE | core in reset, counting down SETTLE_CYCLES
//   RUN    | core released, outputs connected, run_count advancing
//   DRAIN  | core in reset, counting down DRAIN_CYCLES, then back to OFF
// ---------------------------------------------------------------------------
module wrapped_core_gate #(
  parameter int                 IO_PADS       = 38,
  parameter int                 LA_W          = 32,
  parameter int                 SETTLE_CYCLES = 16,
  parameter int                 DRAIN_CYCLES  = 4,
  parameter logic [IO_PADS-1:0] OEB_DEFAULT   = '0,
  parameter bit                 ZERO_WHEN_OFF = 1'b0
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               active,
  input  logic [LA_W-1:0]    la1_data_in,
  input  logic [LA_W-1:0]    la1_oenb,
  input  logic [LA_W-1:0]    core_la_out,
  input  logic [IO_PADS-1:0] core_io_out,
  output logic [LA_W-1:0]    la1_data_out,
  output logic [IO_PADS-1:0] io_out,
  output logic [IO_PADS-1:0] io_oeb,
  output logic               core_rst_o,
  output logic [17:0]        status_o
);

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_SETTLE = 2'b01,
    ST_RUN    = 2'b10,
    ST_DRAIN  = 2'b11
  } state_t;

  localparam logic [7:0] C_SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] C_DRAIN_LOAD  = 8'(DRAIN_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [15:0] r_run_count;
  logic [15:0] w_run_count_nxt;
  logic        r_act_meta;
  logic        r_act_s;
  logic        r_soft_req;
  logic        r_core_rst;
  logic        w_gate_open;
  logic        w_unused_la;

  // Only bit 0 of the CPU LA buses carries meaning here.
  assign w_unused_la = ^{la1_data_in[LA_W-1:1], la1_oenb[LA_W-1:1]};

  // active comes from another domain; two flops before the FSM sees it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_act_meta <= 1'b0;
      r_act_s    <= 1'b0;
      r_soft_req <= 1'b0;
    end else begin
      r_act_meta <= active;
      r_act_s    <= r_act_meta;
      r_soft_req <= la1_data_in[0] & ~la1_oenb[0];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_OFF;
      r_cnt       <= 8'd0;
      r_run_count <= 16'd0;
      r_core_rst  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_run_count <= w_run_count_nxt;
      // Derived from next state so the registered reset lines up with r_state.
      r_core_rst  <= (w_state_nxt != ST_RUN);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_OFF: begin
        if (r_act_s) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = C_SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (!r_act_s) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = C_DRAIN_LOAD;
        end else if (r_cnt == 8'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      ST_RUN: begin
        // Deselection has priority over a coincident soft reset.
        if (!r_act_s) begin
          w_state_nxt = ST_DRAIN;
          w_cnt_nxt   = C_DRAIN_LOAD;
        end else if (r_soft_req) begin
          w_state_nxt = ST_SETTLE;
          w_cnt_nxt   = C_SETTLE_LOAD;
        end
      end
      ST_DRAIN: begin
        // Drain always completes; reselection is only seen once back in OFF.
        if (r_cnt == 8'd0) begin
          w_state_nxt = ST_OFF;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_comb begin
    w_run_count_nxt = r_run_count;
    if (w_state_nxt == ST_SETTLE && r_state != ST_SETTLE) begin
      w_run_count_nxt = 16'd0;
    end else if (r_state == ST_RUN) begin
      w_run_count_nxt = r_run_count + 16'd1;
    end
  end

  // Decoded straight from the state flops so async reset closes it at once.
  assign w_gate_open = (r_state == ST_RUN);

  generate
    if (ZERO_WHEN_OFF) begin : g_gate_zero
      assign la1_data_out = w_gate_open ? core_la_out : '0;
      assign io_out       = w_gate_open ? core_io_out : '0;
      assign io_oeb       = w_gate_open ? OEB_DEFAULT : '0;
    end else begin : g_gate_hiz
      assign la1_data_out = w_gate_open ? core_la_out : {LA_W{1'bz}};
      assign io_out       = w_gate_open ? core_io_out : {IO_PADS{1'bz}};
      assign io_oeb       = w_gate_open ? OEB_DEFAULT : {IO_PADS{1'bz}};
    end
  endgenerate

  assign core_rst_o = r_core_rst;
  assign status_o   = {r_state, r_run_count};

endmodule

// File: tb/tb_wrapped_core_gate.sv
module tb_wrapped_core_gate;

  localparam int           IO_PADS = 38;
  localparam int           LA_W    = 32;
  localparam logic [37:0]  TB_OEB  = 38'h2A_5A5A_A5A5;
  localparam logic [1:0]   S_OFF = 2'b00, S_SET = 2'b01, S_RUN = 2'b10, S_DRN = 2'b11;

  logic               clk = 1'b0;
  logic               rst;
  logic               active;
  logic [LA_W-1:0]    la_in;
  logic [LA_W-1:0]    la_oenb;
  logic [LA_W-1:0]    core_la;
  logic [IO_PADS-1:0] core_io;
  logic [LA_W-1:0]    la_out;
  logic [IO_PADS-1:0] io_out;
  logic [IO_PADS-1:0] io_oeb;
  logic               core_rst;
  logic [17:0]        status;

  int n_cmp = 0;
  int n_err = 0;

  wrapped_core_gate #(
    .IO_PADS(IO_PADS), .LA_W(LA_W), .SETTLE_CYCLES(16), .DRAIN_CYCLES(4),
    .OEB_DEFAULT(TB_OEB), .ZERO_WHEN_OFF(1'b1)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .active(active),
    .la1_data_in(la_in), .la1_oenb(la_oenb), .core_la_out(core_la),
    .core_io_out(core_io), .la1_data_out(la_out), .io_out(io_out),
    .io_oeb(io_oeb), .core_rst_o(core_rst), .status_o(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        act;
    logic        sd;
    logic        so;
    int          adv;
    logic [1:0]  st;
    logic        crst;
    logic [15:0] rc;
  } step_t;

  step_t steps [27];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_gate(input string tag, input bit open);
    chk({tag, ".io_out"}, 64'(io_out), open ? 64'(core_io) : 64'd0);
    chk({tag, ".la_out"}, 64'(la_out), open ? 64'(core_la) : 64'd0);
    chk({tag, ".io_oeb"}, 64'(io_oeb), open ? 64'(TB_OEB) : 64'd0);
  endtask

  initial begin
    //            act sd so adv  state  crst rc
    steps[0]  = '{1, 0, 1, 1,  S_OFF, 1, 16'd0};
    steps[1]  = '{1, 0, 1, 1,  S_OFF, 1, 16'd0};
    steps[2]  = '{1, 0, 1, 1,  S_SET, 1, 16'd0};
    steps[3]  = '{1, 0, 1, 15, S_SET, 1, 16'd0};
    steps[4]  = '{1, 0, 1, 1,  S_RUN, 0, 16'd0};
    steps[5]  = '{1, 0, 1, 5,  S_RUN, 0, 16'd5};
    steps[6]  = '{1, 1, 1, 1,  S_RUN, 0, 16'd6};
    steps[7]  = '{1, 0, 1, 2,  S_RUN, 0, 16'd8};
    steps[8]  = '{1, 1, 0, 1,  S_RUN, 0, 16'd9};
    steps[9]  = '{1, 0, 1, 1,  S_SET, 1, 16'd0};
    steps[10] = '{1, 0, 1, 15, S_SET, 1, 16'd0};
    steps[11] = '{1, 0, 1, 1,  S_RUN, 0, 16'd0};
    steps[12] = '{1, 0, 1, 3,  S_RUN, 0, 16'd3};
    steps[13] = '{0, 0, 1, 1,  S_RUN, 0, 16'd4};
    steps[14] = '{0, 0, 1, 1,  S_RUN, 0, 16'd5};
    steps[15] = '{0, 0, 1, 1,  S_DRN, 1, 16'd6};
    steps[16] = '{1, 0, 1, 2,  S_DRN, 1, 16'd6};
    steps[17] = '{1, 0, 1, 1,  S_DRN, 1, 16'd6};
    steps[18] = '{1, 0, 1, 1,  S_OFF, 1, 16'd6};
    steps[19] = '{1, 0, 1, 1,  S_SET, 1, 16'd0};
    steps[20] = '{1, 0, 1, 5,  S_SET, 1, 16'd0};
    steps[21] = '{0, 0, 1, 1,  S_SET, 1, 16'd0};
    steps[22] = '{0, 0, 1, 1,  S_SET, 1, 16'd0};
    steps[23] = '{0, 0, 1, 1,  S_DRN, 1, 16'd0};
    steps[24] = '{0, 0, 1, 3,  S_DRN, 1, 16'd0};
    steps[25] = '{0, 0, 1, 1,  S_OFF, 1, 16'd0};
    steps[26] = '{0, 0, 1, 20, S_OFF, 1, 16'd0};

    rst     = 1'b1;
    active  = 1'b1;
    la_in   = '0;
    la_oenb = '1;
    core_la = 32'hDEAD_BEEF;
    core_io = 38'h15_A5C3_3C5A;

    #12;
    chk("reset.status", 64'(status), 64'd0);
    chk("reset.core_rst", 64'(core_rst), 64'd1);
    chk_gate("reset", 1'b0);

    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 27; i++) begin
      active     = steps[i].act;
      la_in[0]   = steps[i].sd;
      la_oenb[0] = steps[i].so;
      tick(steps[i].adv);
      chk($sformatf("step%0d.state", i), 64'(status[17:16]), 64'(steps[i].st));
      chk($sformatf("step%0d.core_rst", i), 64'(core_rst), 64'(steps[i].crst));
      chk($sformatf("step%0d.run_count", i), 64'(status[15:0]), 64'(steps[i].rc));
      chk_gate($sformatf("step%0d", i), steps[i].st == S_RUN);
    end

    // Reselect and wait (bounded) for RUN.
    active = 1'b1;
    begin
      int budget;
      budget = 0;
      while (status[17:16] != S_RUN && budget < 100) begin
        tick(1);
        budget++;
      end
      chk("reenter.latency", 64'(budget), 64'd19);
    end

    // Gate follows core data combinationally, without a clock edge.
    for (int p = 0; p < 3; p++) begin
      core_io = 38'(64'h3F_0123_4567 ^ (64'(p) * 64'h11_1111_1111));
      core_la = 32'hC001_0000 + 32'(p * 32'h0101_0101);
      #1;
      chk_gate($sformatf("comb%0d", p), 1'b1);
    end

    // run_count wraps after 65536 cycles.
    tick(65536 + 3);
    chk("wrap.state", 64'(status[17:16]), 64'(S_RUN));
    chk("wrap.run_count", 64'(status[15:0]), 64'd3);

    // Asynchronous reset mid-RUN, no clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.core_rst", 64'(core_rst), 64'd1);
    chk("async_rst.status", 64'(status), 64'd0);
    chk_gate("async_rst", 1'b0);

    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    chk("resume.off", 64'(status[17:16]), 64'(S_OFF));
    tick(2);
    chk("resume.settle", 64'(status[17:16]), 64'(S_SET));
    chk("resume.core_rst", 64'(core_rst), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
